aes_encryption: RTL and testbench
=================================

Name: aes_encryption

Overview:
Iterative AES-256 block encryptor (FIPS-197) for the AES accelerator datapath. It takes one 128-bit plaintext block and one 256-bit cipher key, and returns the 128-bit ciphertext. The block computes one round per clock and expands the key on the fly, so no round-key storage is needed. Valid/ready handshakes on input and output let it sit between an input FIFO and a result consumer.

Parameters:
- none. The key size is fixed at 256 bits (Nk=8) and the round count at 14 (Nr=14).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  plaintext and key are valid.
- ready_o  output  1  block is idle and can accept a job.
- plaintext  input  128  input block; byte 0 is bits [127:120] (FIPS byte order).
- initial_key  input  256  cipher key; w0 is bits [255:224].
- v_o  output  1  ciphertext is valid.
- yumi_i  input  1  consumer takes the ciphertext; legal only while v_o=1.
- ciphertext  output  128  result, same byte order as plaintext.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE, round counter to 0, state and key registers to 0, v_o=0, ciphertext=0, ready_o=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On v_i&ready_o the block captures the job: state <= plaintext ^ initial_key[255:128] (AddRoundKey 0), key window <= initial_key, round <= 1, FSM moves to RUN.
  - Inputs are sampled only on this edge; later input changes have no effect.
- RUN:
  - ready_o=0.
  - Each edge applies round r: SubBytes, ShiftRows, MixColumns (MixColumns skipped when r=14), then AddRoundKey with rk_r.
  - rk_r is the current key window's lower half, i.e. w[4r..4r+3].
  - On r=14 the FSM loads the ciphertext register and moves to DONE.
- Key window:
  - A 256-bit register holds w[4r-4..4r+3].
  - Each round it shifts left by 128 bits and appends 4 new words, using the standard recurrence w[i]=w[i-8]^temp.
  - For i%8==0: temp = SubWord(RotWord(w[i-1]))^Rcon[i/8]. Rcon runs 01,02,04,08,10,20,40 in the MSB.
  - For i%8==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- Latency: v_o rises exactly 14 clock edges after the accept edge, i.e. 15 edges including the accept edge.
- DONE:
  - v_o=1 and ciphertext is stable.
  - On yumi_i the FSM returns to IDLE and v_o goes to 0; ciphertext keeps its last value.
  - The next accept is possible on the cycle after yumi_i (no same-cycle re-accept).
- v_i while not ready: ignored; no job is queued.
- yumi_i while v_o=0: ignored.
- reset_i mid-job: the job is aborted immediately and the block returns to the reset state. No partial result is ever flagged valid.
- All S-boxes are combinational (20 instances: 16 for the state, 4 for the key). GF(2^8) xtime uses polynomial 0x11B.

Decomposition:
- Shared package aes_pkg holds:
  - the Rcon constant table and a constant for the round count (14);
  - functions xtime, mix_column, shift_rows and sub_word, plus a typedef for a 128-bit state as a 4x4 byte array.
- One sub-module, aes_sbox: 8-bit in/out, forward S-box as a 256-entry case ROM or composite-field logic.

Test Plan:
- FIPS-197 C.3:
  - Stimulus: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f.
  - Required: ciphertext=8ea2b7ca516745bfeafc49904b496089, with v_o rising 14 edges after accept.
- All-zero plaintext and all-zero key:
  - Required: ciphertext=dc95c078a2408989ad48a21492842087.
- Handshake:
  - Hold yumi_i=0 for 10 cycles after v_o: v_o and ciphertext stay stable, ready_o=0.
  - Pulse v_i during RUN: the pulse is ignored.
  - Assert yumi_i: IDLE on the next cycle with ready_o=1.
- Back-to-back jobs:
  - Run C.3 then the all-zero job, each yumi'd immediately: both results are correct, and the second accept comes 1 cycle after yumi_i.
- Reset:
  - Assert reset_i asynchronously at round 7: v_o=0, ready_o=1 and ciphertext=0 without waiting for a clock edge.
  - A new C.3 job afterwards returns the correct result.
- Input isolation:
  - Change plaintext and key on the edge after accept: the result is still the C.3 value.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-256 definitions: state typedef, FSM encoding, S-box ROM, Rcon table
// and the round helper functions used by the iterative encryptor.
package aes_pkg;

    // Column-major state: index [col][row], byte 0 of the block sits at [0][0].
    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd14;

    // Only entries 0..6 are consumed; the eighth keeps every index in range.
    localparam logic [0:7][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

    localparam logic [0:255][7:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_ROM[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        o = {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
             sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
        return o;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            o[2'(c)] = mix_column(s[2'(c)]);
        end
        return o;
    endfunction

    // Row r rotates left by r bytes.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[2'(c)][2'(r)] = s[2'(c + r)][2'(r)];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_encryption_if.sv
// Job/result handshake bundle of the AES-256 encryptor: valid/ready on the
// input side, valid/yumi on the result side.
interface aes_encryption_if;

    logic         v_i;
    logic         ready_o;
    logic [127:0] plaintext;
    logic [255:0] initial_key;
    logic         v_o;
    logic         yumi_i;
    logic [127:0] ciphertext;

    modport master (
        output v_i,
        output plaintext,
        output initial_key,
        output yumi_i,
        input  ready_o,
        input  v_o,
        input  ciphertext
    );

    modport slave (
        input  v_i,
        input  plaintext,
        input  initial_key,
        input  yumi_i,
        output ready_o,
        output v_o,
        output ciphertext
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational ROM lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_byte(in_byte);

endmodule

// File: rtl/aes_encryption.sv
// Iterative AES-256 encryptor: one round per clock, key schedule expanded on
// the fly through a sliding 256-bit window of expanded-key words.
module aes_encryption
    import aes_pkg::*;
(
    input  logic           clk_i,
    input  logic           reset_i,
    aes_encryption_if.slave bus
);

    aes_fsm_t      state_r;
    aes_fsm_t      next_state_s;
    logic [3:0]    round_r;
    aes_state_t    blk_r;
    logic [255:0]  key_r;
    logic          ready_r;
    logic          v_r;
    logic [127:0]  ct_r;

    logic          accept_s;
    logic          last_round_s;
    aes_state_t    sub_s;
    aes_state_t    shifted_s;
    aes_state_t    mixed_s;
    aes_state_t    round_out_s;
    logic [31:0]   key_sub_s;
    logic [31:0]   key_temp_s;
    logic [31:0]   nw0_s, nw1_s, nw2_s, nw3_s;
    logic [255:0]  key_next_s;

    assign accept_s     = bus.v_i & ready_r;
    assign last_round_s = (round_r == LAST_ROUND);

    for (genvar g = 0; g < 16; g++) begin : g_state_sbox
        aes_sbox u_sbox (
            .in_byte  (blk_r[g / 4][g % 4]),
            .out_byte (sub_s[g / 4][g % 4])
        );
    end

    // Only the first new word of each round needs SubWord, taken from w[4r+3].
    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (
            .in_byte  (key_r[31 - 8 * g -: 8]),
            .out_byte (key_sub_s[31 - 8 * g -: 8])
        );
    end

    // Round datapath: ShiftRows/MixColumns on the substituted state, then AddRoundKey.
    always_comb begin
        shifted_s = shift_rows(sub_s);
        mixed_s   = mix_columns(shifted_s);
        if (last_round_s) begin
            round_out_s = shifted_s ^ key_r[127:0];
        end else begin
            round_out_s = mixed_s ^ key_r[127:0];
        end
    end

    // Key window advance: odd rounds start a new 8-word group (RotWord + Rcon),
    // even rounds sit at i%8==4 and only substitute.
    always_comb begin
        if (round_r[0]) begin
            key_temp_s = {key_sub_s[23:0], key_sub_s[31:24]} ^ {RCON[round_r[3:1]], 24'h000000};
        end else begin
            key_temp_s = key_sub_s;
        end
        nw0_s      = key_r[255:224] ^ key_temp_s;
        nw1_s      = key_r[223:192] ^ nw0_s;
        nw2_s      = key_r[191:160] ^ nw1_s;
        nw3_s      = key_r[159:128] ^ nw2_s;
        key_next_s = {key_r[127:0], nw0_s, nw1_s, nw2_s, nw3_s};
    end

    // Next-state decode of the job FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_round_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.yumi_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register with registered handshake flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            v_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == ST_IDLE);
            v_r     <= (next_state_s == ST_DONE);
        end
    end

    // Datapath registers: capture on accept, iterate in RUN, latch result on the last round.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            round_r <= 4'd0;
            blk_r   <= '0;
            key_r   <= '0;
            ct_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        blk_r   <= bus.plaintext ^ bus.initial_key[255:128];
                        key_r   <= bus.initial_key;
                        round_r <= 4'd1;
                    end
                end
                ST_RUN: begin
                    blk_r <= round_out_s;
                    key_r <= key_next_s;
                    if (last_round_s) begin
                        ct_r    <= round_out_s;
                        round_r <= 4'd0;
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                default: begin
                    round_r <= round_r;
                end
            endcase
        end
    end

    assign bus.ready_o    = ready_r;
    assign bus.v_o        = v_r;
    assign bus.ciphertext = ct_r;

endmodule

// File: tb/tb_aes_encryption.sv
// Directed bench for the AES-256 encryptor using FIPS-197 C.3 and the
// all-zero known answer, plus handshake, back-to-back, reset and isolation cases.
module tb_aes_encryption;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;

    localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

    aes_encryption_if bus();

    aes_encryption dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic start_job(input logic [127:0] pt, input logic [255:0] key);
        bus.plaintext   = pt;
        bus.initial_key = key;
        bus.v_i         = 1'b1;
        @(posedge clk); #1;
        bus.v_i = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (bus.v_o !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic take_result();
        bus.yumi_i = 1'b1;
        @(posedge clk); #1;
        bus.yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.v_o, bus.ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags: v_o,ready_o=%b expected 01", {bus.v_o, bus.ready_o});
        end
        checks++;
        if (bus.ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_ct: got %h expected 0", bus.ciphertext);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b expected 1", bus.ready_o);
        end
    endtask

    task automatic test_fips_c3();
        start_job(PT_C3, KEY_C3);
        wait_valid(n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL c3_latency: got %0d expected 14", n);
        end
        checks++;
        if (bus.ciphertext !== CT_C3) begin
            errors++;
            $display("FAIL c3_ct: got %h expected %h", bus.ciphertext, CT_C3);
        end
        take_result();
        checks++;
        if ({bus.v_o, bus.ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL c3_yumi: v_o,ready_o=%b expected 01", {bus.v_o, bus.ready_o});
        end
    endtask

    task automatic test_all_zero();
        start_job(128'h0, 256'h0);
        wait_valid(n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 14", n);
        end
        checks++;
        if (bus.ciphertext !== CT_ZERO) begin
            errors++;
            $display("FAIL zero_ct: got %h expected %h", bus.ciphertext, CT_ZERO);
        end
        take_result();
    endtask

    task automatic test_handshake();
        start_job(PT_C3, KEY_C3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.plaintext   = 128'h0;
        bus.initial_key = 256'h0;
        bus.v_i         = 1'b1;
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hs_run_ready: got %b expected 0", bus.ready_o);
        end
        wait_valid(n);
        checks++;
        if (n + 3 !== 14) begin
            errors++;
            $display("FAIL hs_latency: got %0d expected 14", n + 3);
        end
        checks++;
        if (bus.ciphertext !== CT_C3) begin
            errors++;
            $display("FAIL hs_ct: got %h expected %h", bus.ciphertext, CT_C3);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.v_o, bus.ready_o, bus.ciphertext} !== {2'b10, CT_C3}) begin
                errors++;
                $display("FAIL hs_hold_%0d: v_o=%b ready_o=%b ct=%h expected v_o=1 ready_o=0 ct=%h",
                         i, bus.v_o, bus.ready_o, bus.ciphertext, CT_C3);
            end
        end
        take_result();
        checks++;
        if ({bus.v_o, bus.ready_o, bus.ciphertext} !== {2'b01, CT_C3}) begin
            errors++;
            $display("FAIL hs_release: v_o=%b ready_o=%b ct=%h expected v_o=0 ready_o=1 ct=%h",
                     bus.v_o, bus.ready_o, bus.ciphertext, CT_C3);
        end
        bus.yumi_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.yumi_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.v_o, bus.ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL hs_idle_yumi: v_o,ready_o=%b expected 01", {bus.v_o, bus.ready_o});
        end
    endtask

    task automatic test_back_to_back();
        start_job(PT_C3, KEY_C3);
        wait_valid(n);
        checks++;
        if (bus.ciphertext !== CT_C3) begin
            errors++;
            $display("FAIL b2b_first_ct: got %h expected %h", bus.ciphertext, CT_C3);
        end
        take_result();
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_yumi: got %b expected 1", bus.ready_o);
        end
        start_job(128'h0, 256'h0);
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: ready_o=%b expected 0", bus.ready_o);
        end
        wait_valid(n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected 14", n);
        end
        checks++;
        if (bus.ciphertext !== CT_ZERO) begin
            errors++;
            $display("FAIL b2b_second_ct: got %h expected %h", bus.ciphertext, CT_ZERO);
        end
        take_result();
    endtask

    task automatic test_reset_abort();
        start_job(PT_C3, KEY_C3);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.v_o, bus.ready_o, bus.ciphertext} !== {2'b01, 128'h0}) begin
            errors++;
            $display("FAIL abort_async: v_o=%b ready_o=%b ct=%h expected v_o=0 ready_o=1 ct=0",
                     bus.v_o, bus.ready_o, bus.ciphertext);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_job(PT_C3, KEY_C3);
        wait_valid(n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL abort_rerun_latency: got %0d expected 14", n);
        end
        checks++;
        if (bus.ciphertext !== CT_C3) begin
            errors++;
            $display("FAIL abort_rerun_ct: got %h expected %h", bus.ciphertext, CT_C3);
        end
        take_result();
    endtask

    task automatic test_isolation();
        start_job(PT_C3, KEY_C3);
        bus.plaintext   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        bus.initial_key = {KEY_C3[127:0], 128'h55aa55aa_33cc33cc_0ff00ff0_a5a5a5a5};
        wait_valid(n);
        checks++;
        if (bus.ciphertext !== CT_C3) begin
            errors++;
            $display("FAIL iso_ct: got %h expected %h", bus.ciphertext, CT_C3);
        end
        take_result();
    endtask

    initial begin
        bus.v_i         = 1'b0;
        bus.yumi_i      = 1'b0;
        bus.plaintext   = 128'h0;
        bus.initial_key = 256'h0;
        test_reset();
        test_fips_c3();
        test_all_zero();
        test_handshake();
        test_back_to_back();
        test_reset_abort();
        test_isolation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
